// File: rtl/otp_pkg.sv
// Shared definitions for the OTP digit generator: FSM encoding, LFSR
// defaults, digit geometry and the candidate-folding helper.
package otp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GEN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] TAPS_DEFAULT = 16'hB400;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int K_W        = $clog2(NUM_DIGITS);

  // Map a raw nibble onto a decimal digit: 10..15 fold down to 0..5.
  function automatic logic [3:0] fold_digit(input logic [3:0] cand);
    return (cand > 4'd9) ? cand - 4'd10 : cand;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous seed load.
// A zero seed would lock the register at zero, so it is replaced by SEED.
module lfsr16
  import otp_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT,
  parameter logic [15:0] TAPS = TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load_i,
  input  logic [15:0] seed_val_i,
  output logic [3:0]  nibble_o
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next value: advance by one step unless a seed load takes priority.
  always_comb begin
    // NOTE: assign a default before any condition so every path drives
    // value_d; a missing branch would otherwise infer a latch.
    value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : 16'h0000);
    if (seed_load_i) begin
      value_d = (seed_val_i == 16'h0000) ? SEED : seed_val_i;
    end
  end

  // LFSR state register; comes out of reset holding SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign nibble_o = value_q[3:0];

endmodule

// File: rtl/otp_digit_gen.sv
// Four-digit BCD one-time-password generator. A request in IDLE starts
// GEN, which takes the LFSR low nibble each cycle as a digit candidate;
// after four accepted digits DONE pulses lfsr_latch for one cycle.
// Build option: define OTP_REJECT_SAMPLING_EN to reject candidates above 9
// (uniform digits, variable latency); otherwise 10..15 fold to 0..5 and
// latency is fixed.
module otp_digit_gen
  import otp_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT,
  parameter logic [15:0] TAPS = TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gen_req,
  input  logic        seed_load,
  input  logic [15:0] seed_val,
  output logic [15:0] lfsr_digit,
  output logic        lfsr_latch,
  output logic        busy
);

  state_e                          state_q, state_d;
  logic [K_W-1:0]                  k_q, k_d;
  logic [NUM_DIGITS*DIGIT_W-1:0]   slots_q, slots_d;
  logic [NUM_DIGITS*DIGIT_W-1:0]   digit_q, digit_d;

  logic [3:0] cand_nib;
  logic [3:0] cand_digit;
  logic       cand_ok;
  logic       last_slot;

  lfsr16 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk         (clk),
    .rst_n       (reset),
    .seed_load_i (seed_load),
    .seed_val_i  (seed_val),
    .nibble_o    (cand_nib)
  );

`ifdef OTP_REJECT_SAMPLING_EN
  assign cand_ok    = (cand_nib <= 4'd9);
  assign cand_digit = cand_nib;
`else
  assign cand_ok    = 1'b1;
  assign cand_digit = fold_digit(cand_nib);
`endif

  assign last_slot = (k_q == K_W'(NUM_DIGITS - 1));

  // State register plus digit-assembly registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      slots_q <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      slots_q <= slots_d;
      digit_q <= digit_d;
    end
  end

  // Next-state logic; a seed load in GEN restarts assembly, never finishes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gen_req) state_d = GEN;
      GEN:     if (!seed_load && cand_ok && last_slot) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Digit assembly: fill slot k (digit 0 in the top nibble) and publish
  // the full word on the edge that enters DONE.
  always_comb begin
    k_d     = k_q;
    slots_d = slots_q;
    digit_d = digit_q;
    case (state_q)
      IDLE: begin
        if (gen_req) begin
          k_d     = '0;
          slots_d = '0;
        end
      end
      GEN: begin
        if (seed_load) begin
          k_d     = '0;
          slots_d = '0;
        end else if (cand_ok) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k_q == K_W'(i)) begin
              slots_d[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = cand_digit;
            end
          end
          k_d = k_q + K_W'(1);
          if (last_slot) begin
            digit_d = slots_d;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state and the published word.
  always_comb begin
    lfsr_latch = (state_q == DONE);
    busy       = (state_q == GEN);
    lfsr_digit = digit_q;
  end

endmodule

// File: tb/tb_otp_digit_gen.sv
// Directed self-checking bench for otp_digit_gen. A reference LFSR is
// stepped alongside the DUT and the expected OTP is derived from it.
module tb_otp_digit_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset;
  logic        gen_req;
  logic        seed_load;
  logic [15:0] seed_val;
  logic [15:0] lfsr_digit;
  logic        lfsr_latch;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_lfsr;

  otp_digit_gen dut (
    .clk        (clk),
    .reset      (reset),
    .gen_req    (gen_req),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .lfsr_digit (lfsr_digit),
    .lfsr_latch (lfsr_latch),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; the reference LFSR follows the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!reset)         m_lfsr = SEED;
    else if (seed_load) m_lfsr = (seed_val == 16'h0000) ? SEED : seed_val;
    else                m_lfsr = step(m_lfsr);
    #1;
  endtask

  // Expected OTP from the LFSR value of the first GEN cycle.
  task automatic predict(input logic [15:0] start, output logic [15:0] otp,
                         output int n_gen);
    logic [15:0] v;
    logic [3:0]  c;
    int          k;
    v = start; k = 0; n_gen = 0; otp = 16'h0000;
    while (k < 4 && n_gen < 200) begin
      c = v[3:0];
      n_gen++;
`ifdef OTP_REJECT_SAMPLING_EN
      if (c <= 4'd9) begin
        otp = {otp[11:0], c};
        k++;
      end
`else
      otp = {otp[11:0], (c > 4'd9) ? c - 4'd10 : c};
      k++;
`endif
      v = step(v);
    end
  endtask

  // Tick until lfsr_latch is seen; gen_req drops once req_hold ticks pass.
  task automatic wait_latch(input int budget, input int req_hold, output int lat);
    lat = 0;
    while (lat < budget) begin
      tick();
      lat++;
      if (lat >= req_hold) gen_req = 1'b0;
      if (lfsr_latch === 1'b1) break;
    end
    if (lfsr_latch !== 1'b1) begin
      check("latch_timeout", 32'd0, 32'd1);
      lat = -1;
    end
  endtask

  // Full request: gen_req sampled, wait for DONE, verify word and pulse width.
  task automatic run_otp(input string tag, input int req_hold,
                         output logic [15:0] exp);
    int n_gen;
    int lat;
    gen_req = 1'b1;
    tick();
    if (req_hold == 0) gen_req = 1'b0;
    predict(m_lfsr, exp, n_gen);
    wait_latch(300, req_hold, lat);
`ifdef OTP_REJECT_SAMPLING_EN
    check({tag, "_lat_min"}, 32'(lat + 1 >= 5), 32'd1);
    check({tag, "_lat"}, lat + 1, n_gen + 1);
`else
    check({tag, "_lat"}, lat + 1, 32'd5);
`endif
    check({tag, "_digit"}, lfsr_digit, exp);
    check({tag, "_bcd"}, 32'(bcd_ok(lfsr_digit)), 32'd1);
    tick();
    check({tag, "_pulse"}, lfsr_latch, 32'd0);
    check({tag, "_hold"}, lfsr_digit, exp);
  endtask

  initial begin
    logic [15:0] exp;
    int          cnt;
    int          n_gen;
    int          lat;

    reset = 1'b0; gen_req = 1'b0; seed_load = 1'b0; seed_val = 16'h0000;
    m_lfsr = SEED;
    repeat (3) tick();
    check("rst_digit", lfsr_digit, 16'h0000);
    check("rst_latch", lfsr_latch, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_lfsr", dut.u_lfsr.value_q, 16'hACE1);

    // Release with no request: LFSR advances, nothing latches.
    reset = 1'b1;
    tick();
    check("lfsr_adv", dut.u_lfsr.value_q, 16'hE270);
    cnt = 0;
    repeat (99) begin
      tick();
      if (lfsr_latch !== 1'b0 || busy !== 1'b0) cnt++;
    end
    check("idle_no_latch", cnt, 0);
    check("idle_digit", lfsr_digit, 16'h0000);
    check("idle_lfsr_track", dut.u_lfsr.value_q, m_lfsr);

    // Zero seed is replaced by the default seed.
    seed_load = 1'b1; seed_val = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("seed_zero", dut.u_lfsr.value_q, 16'hACE1);

    // Seed 0x1234, request on the following cycle.
    seed_load = 1'b1; seed_val = 16'h1234;
    tick();
    seed_load = 1'b0;
    check("seed_1234", dut.u_lfsr.value_q, 16'h1234);
    run_otp("otp1234", 0, exp);
    repeat (10) tick();
    check("hold_10", lfsr_digit, exp);

    // Another seed, with gen_req held into GEN (must not queue a second run).
    seed_load = 1'b1; seed_val = 16'hBEEF;
    tick();
    seed_load = 1'b0;
    run_otp("otpbeef", 3, exp);
    repeat (3) tick();
    check("genreq_in_gen_ignored", busy, 1'b0);

    // Back-to-back request from a free-running LFSR.
    run_otp("otpfree", 0, exp);

    // Seed load in the middle of GEN restarts assembly from the new seed.
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    tick();
    tick();
    seed_load = 1'b1; seed_val = 16'h5A5A;
    tick();
    seed_load = 1'b0;
    check("reload_lfsr", dut.u_lfsr.value_q, 16'h5A5A);
    check("reload_busy", busy, 1'b1);
    predict(16'h5A5A, exp, n_gen);
    wait_latch(300, 0, lat);
    check("reload_delay", 32'(lat >= 4), 32'd1);
    check("reload_lat", lat, n_gen);
    check("reload_digit", lfsr_digit, exp);
    tick();

    // gen_req during DONE is dropped: block returns to IDLE and stays.
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    predict(m_lfsr, exp, n_gen);
    wait_latch(300, 0, lat);
    check("done_digit", lfsr_digit, exp);
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    check("done_req_busy", busy, 1'b0);
    check("done_req_latch", lfsr_latch, 1'b0);
    cnt = 0;
    repeat (8) begin
      tick();
      if (busy !== 1'b0 || lfsr_latch !== 1'b0) cnt++;
    end
    check("done_req_idle", cnt, 0);

    // Reset asserted mid-GEN aborts without a latch pulse.
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_digit", lfsr_digit, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_lfsr", dut.u_lfsr.value_q, 16'hACE1);
    cnt = 0;
    repeat (2) begin
      tick();
      if (lfsr_latch !== 1'b0) cnt++;
    end
    reset = 1'b1;
    repeat (20) begin
      tick();
      if (lfsr_latch !== 1'b0 || busy !== 1'b0) cnt++;
    end
    check("midrst_no_latch", cnt, 0);
    check("midrst_digit_after", lfsr_digit, 16'h0000);
    check("midrst_lfsr_track", dut.u_lfsr.value_q, m_lfsr);

    // Normal operation resumes after the abort.
    run_otp("otpafter", 0, exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otp_digit_gen.md
OTP_DIGIT_GEN -- requirements
Module: otp_digit_gen

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset and substitute seed (must be non-zero).
REQ-002 The block SHALL have parameter TAPS, default 16'hB400, giving the Galois feedback mask for x^16+x^14+x^13+x^11+1.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port gen_req, input, 1, request for a new 4-digit OTP; sampled only in IDLE.
REQ-006 The block SHALL have port seed_load, input, 1, loads seed_val into the LFSR on this cycle.
REQ-007 The block SHALL have port seed_val, input, 16, new LFSR seed.
REQ-008 The block SHALL have port lfsr_digit, output, 16, OTP as four BCD nibbles, digit 0 in [15:12].
REQ-009 The block SHALL have port lfsr_latch, output, 1, one-cycle pulse marking lfsr_digit valid and new.
REQ-010 The block SHALL have port busy, output, 1, high while in GEN.

Function
REQ-011 The LFSR SHALL be 16-bit Galois, shift right: next = (q>>1) ^ (q[0] ? TAPS : 0), and SHALL advance every cycle in every state, so the OTP depends on request timing.
REQ-012 On seed_load, the LFSR SHALL take seed_val, or SEED if seed_val==0, instead of advancing; seed_load SHALL win over advancing.
REQ-013 The state machine SHALL have states IDLE, GEN and DONE.
REQ-014 IDLE->GEN SHALL occur when gen_req==1; the digit index k is cleared to 0 on that edge.
REQ-015 In GEN, the candidate each cycle SHALL be the low nibble of the current LFSR value; when accepted it is written to slot k and k increments.
REQ-016 GEN->DONE SHALL occur on the cycle the 4th digit (k==3) is accepted.
REQ-017 DONE SHALL last one cycle: lfsr_latch=1, lfsr_digit shows the 4 assembled digits, then return to IDLE.
REQ-018 lfsr_digit SHALL hold its value between latches.
REQ-019 lfsr_latch SHALL be 0 in every state except DONE.
REQ-020 Minimum request-to-latch latency SHALL be 5 cycles: gen_req sampled, 4 GEN cycles, DONE.
REQ-021 seed_load during GEN SHALL restart assembly: k=0, partial digits discarded, remain in GEN.
REQ-022 gen_req in GEN or DONE SHALL be ignored; it is not queued.
REQ-023 Every nibble of lfsr_digit SHALL be in 0..9 in both configurations.

Reset
REQ-024 While reset==0, the block SHALL hold: state=IDLE, LFSR=SEED, k=0, lfsr_digit=16'h0000, lfsr_latch=0, busy=0.
REQ-025 Reset asserted mid-GEN SHALL abort with no latch pulse.
REQ-026 After reset deassertion, the first state transition SHALL occur at the next rising clk edge.

Configuration
REQ-027 With OTP_REJECT_SAMPLING_EN defined, candidates >9 SHALL be rejected: no write, k unchanged, latency may exceed 5 cycles.
REQ-028 Without OTP_REJECT_SAMPLING_EN, every candidate SHALL be accepted, with values 10..15 mapped to candidate-10 (0..5); latency is then exactly 5 cycles.

Structure
REQ-029 Package otp_pkg SHALL hold the state encoding (IDLE=2'b00, GEN=2'b01, DONE=2'b10), the SEED default, the TAPS default, and NUM_DIGITS=4.
REQ-030 The LFSR with seed-load and zero substitution SHALL be sub-module lfsr16; FSM and digit assembly stay in otp_digit_gen.

Verification
REQ-031 The bench SHALL release reset with no request and check that lfsr_digit==16'h0000, lfsr_latch stays 0 for 100 cycles, and the LFSR advances from 16'hACE1.
REQ-032 The bench SHALL apply seed_load with seed_val=16'h0000 and check that the LFSR holds 16'hACE1 the next cycle.
REQ-033 The bench SHALL apply seed_load=16'h1234, then gen_req for 1 cycle the following cycle, and check that lfsr_digit matches a bit-accurate model, every nibble is <=9, and lfsr_latch is exactly 1 cycle wide.
REQ-034 With OTP_REJECT_SAMPLING_EN undefined, the bench SHALL issue gen_req and check latch exactly 5 cycles later; with the macro defined, it SHALL check latency >=5 and match the model.
REQ-035 The bench SHALL assert seed_load during GEN and check that k restarts, the latch is delayed by at least 4 cycles, and digits come only from post-load values.
REQ-036 The bench SHALL pulse reset mid-GEN and gen_req during DONE, and check no latch, lfsr_digit==0 after reset, and the DONE request ignored (state returns to IDLE).
